// File: rtl/param_rdcache.sv
// param_rdcache: direct-mapped read-only cache for 32-bit parameter words.
// Requests are base + byte offset; hits return a registered word one edge
// after acceptance. Misses fill a whole 128-byte line (16 x 64-bit beats)
// through a fixed-length burst read port. There is no write path.
module param_rdcache #(
  parameter int NLINE = 4,
  parameter int BLEN  = 16
) (
  input  logic        aclk,
  input  logic        arst_n,
  input  logic        clr,
  input  logic [31:0] base,
  input  logic [31:0] adr,
  input  logic        re,
  output logic        rdy,
  output logic [31:0] dr,
  output logic        rreq,
  input  logic        rack,
  output logic [31:0] radr,
  output logic [7:0]  rlen,
  input  logic [63:0] rdata
);

  localparam int IW = $clog2(NLINE);
  localparam int TW = 25 - IW;
  localparam logic [3:0] LAST_BEAT = 4'(BLEN - 1);

  typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [31:0]     ea_s;
  logic [IW-1:0]   idx_s;
  logic [TW-1:0]   tag_s;
  logic [3:0]      beat_s;
  logic            half_s;
  logic            hit_s;
  logic            miss_s;
  logic            accept_s;
  logic            last_s;
  logic [63:0]     rd_beat_s;
  logic [31:0]     rd_word_s;
  logic            unused_ok_s;

  logic [63:0]     data_r [NLINE*16];
  logic [TW-1:0]   tag_r  [NLINE];
  logic [NLINE-1:0] valid_r;
  logic [IW-1:0]   fill_idx_r;
  logic [TW-1:0]   fill_tag_r;
  logic            keep_r;
  logic [3:0]      cnt_r;
  logic [31:0]     radr_r;
  logic            rreq_r;
  logic [31:0]     dr_r;

  // Address decode and hit detection against the current (pre-clear) state.
  assign ea_s        = base + adr;
  assign idx_s       = ea_s[6+IW:7];
  assign tag_s       = ea_s[31:7+IW];
  assign beat_s      = ea_s[6:3];
  assign half_s      = ea_s[2];
  assign unused_ok_s = &{1'b0, ea_s[1:0]};
  assign hit_s       = valid_r[idx_s] && (tag_r[idx_s] == tag_s);
  assign miss_s      = (state_r == IDLE) && re && !hit_s;
  assign accept_s    = (state_r == IDLE) && re && hit_s;
  assign last_s      = (state_r == FILL) && rack && (cnt_r == LAST_BEAT);
  assign rd_beat_s   = data_r[{idx_s, beat_s}];
  assign rd_word_s   = half_s ? rd_beat_s[63:32] : rd_beat_s[31:0];

  assign rdy  = (state_r == IDLE) && !(re && !hit_s);
  assign dr   = dr_r;
  assign rreq = rreq_r;
  assign radr = radr_r;
  assign rlen = 8'(BLEN - 1);

  // Next-state logic: leave Idle on a miss, return after the final beat.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (miss_s) state_nxt_s = FILL;
        else        state_nxt_s = IDLE;
      end
      FILL: begin
        if (last_s) state_nxt_s = IDLE;
        else        state_nxt_s = FILL;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) state_r <= IDLE;
    else         state_r <= state_nxt_s;
  end

  // Fill bookkeeping: burst request, beat counter, target line and keep flag.
  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      rreq_r     <= 1'b0;
      radr_r     <= 32'h0000_0000;
      cnt_r      <= 4'd0;
      keep_r     <= 1'b0;
      fill_idx_r <= {IW{1'b0}};
      fill_tag_r <= {TW{1'b0}};
    end else if (miss_s) begin
      rreq_r     <= 1'b1;
      radr_r     <= {ea_s[31:7], 7'h00};
      cnt_r      <= 4'd0;
      keep_r     <= 1'b1;
      fill_idx_r <= idx_s;
      fill_tag_r <= tag_s;
    end else if (state_r == FILL) begin
      if (rack) cnt_r <= cnt_r + 4'd1;
      if (last_s) rreq_r <= 1'b0;
      // A clear during the burst means the incoming line may be stale.
      if (clr) keep_r <= 1'b0;
    end
  end

  // Tag and valid arrays; a clear always wins over validating a finished fill.
  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      valid_r <= {NLINE{1'b0}};
      for (int i = 0; i < NLINE; i++) tag_r[i] <= {TW{1'b0}};
    end else begin
      if (last_s) tag_r[fill_idx_r] <= fill_tag_r;
      if (clr) valid_r <= {NLINE{1'b0}};
      else if (last_s && keep_r) valid_r[fill_idx_r] <= 1'b1;
    end
  end

  // Line data storage written one beat per rack during a fill.
  always_ff @(posedge aclk) begin
    if ((state_r == FILL) && rack) data_r[{fill_idx_r, cnt_r}] <= rdata;
  end

  // Registered read data; holds when no access is accepted.
  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n)       dr_r <= 32'h0000_0000;
    else if (accept_s) dr_r <= rd_word_s;
  end

endmodule

// File: tb/tb_param_rdcache.sv
// Directed testbench for param_rdcache: cold miss, streaming hits, line
// crossing and eviction, clear during/after fills, rack gaps, reset mid-fill.
module tb_param_rdcache;

  localparam logic [31:0] B = 32'h1000_0000;

  logic        aclk;
  logic        arst_n;
  logic        clr;
  logic [31:0] base;
  logic [31:0] adr;
  logic        re;
  logic        rdy;
  logic [31:0] dr;
  logic        rreq;
  logic        rack;
  logic [31:0] radr;
  logic [7:0]  rlen;
  logic [63:0] rdata;

  int total = 0;
  int bad   = 0;

  param_rdcache #(.NLINE(4), .BLEN(16)) dut (
    .aclk(aclk), .arst_n(arst_n), .clr(clr), .base(base), .adr(adr),
    .re(re), .rdy(rdy), .dr(dr), .rreq(rreq), .rack(rack), .radr(radr),
    .rlen(rlen), .rdata(rdata)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Memory image: the 32-bit word at byte address a holds (a - B) / 4.
  function automatic logic [31:0] mem_word(input logic [31:0] line, input int k);
    return ((line - B) >> 2) + 32'(k);
  endfunction

  // Present a miss at offset a, serve the burst for line, then check the
  // re-evaluated access. gap!=0 toggles rack starting low; clr_at>=0 pulses
  // clr on that beat, after which the line must not be valid.
  task automatic miss_and_fill(input logic [31:0] a, input logic [31:0] line,
                               input int gap, input int clr_at, output int cycles);
    int sent;
    logic phase;
    logic [31:0] exp_w;
    sent = 0; phase = 1'b0; cycles = 0;
    exp_w = mem_word(line, int'((a & 32'h7F) >> 2));
    adr = a; re = 1'b1;
    #1;
    total++; if (rdy !== 1'b0) begin bad++; $display("FAIL miss_rdy @%0h: got %0b want 0", a, rdy); end
    @(posedge aclk); #1;
    total++; if (rreq !== 1'b1) begin bad++; $display("FAIL rreq_rise @%0h: got %0b want 1", a, rreq); end
    total++; if (radr !== line) begin bad++; $display("FAIL radr @%0h: got %0h want %0h", a, radr, line); end
    total++; if (rlen !== 8'd15) begin bad++; $display("FAIL rlen: got %0d want 15", rlen); end
    while (sent < 16 && cycles < 200) begin
      rack  = (gap == 0) ? 1'b1 : phase;
      phase = ~phase;
      rdata = {mem_word(line, 2*sent+1), mem_word(line, 2*sent)};
      clr   = (sent == clr_at) && rack;
      #1;
      total++; if (rdy !== 1'b0) begin bad++; $display("FAIL fill_rdy beat%0d: got %0b want 0", sent, rdy); end
      @(posedge aclk); #1;
      cycles++;
      if (rack) sent++;
      clr = 1'b0;
      if (sent < 16) begin
        total++;
        if (rreq !== 1'b1 || radr !== line) begin
          bad++; $display("FAIL fill_hold beat%0d: rreq=%0b radr=%0h want 1 %0h", sent, rreq, radr, line);
        end
      end
    end
    rack = 1'b0; rdata = 64'h0;
    total++; if (cycles >= 200) begin bad++; $display("FAIL fill_timeout: got %0d cycles want <200", cycles); end
    total++; if (rreq !== 1'b0) begin bad++; $display("FAIL rreq_drop: got %0b want 0", rreq); end
    #1;
    if (clr_at >= 0) begin
      total++; if (rdy !== 1'b0) begin bad++; $display("FAIL not_validated @%0h: got rdy=%0b want 0", a, rdy); end
      re = 1'b0;
    end else begin
      total++; if (rdy !== 1'b1) begin bad++; $display("FAIL post_fill_rdy @%0h: got %0b want 1", a, rdy); end
      @(posedge aclk); #1;
      re = 1'b0;
      total++; if (dr !== exp_w) begin bad++; $display("FAIL post_fill_dr @%0h: got %0h want %0h", a, dr, exp_w); end
    end
  endtask

  // One accepted hit at offset a, expecting word w with no fill.
  task automatic hit_read(input logic [31:0] a, input logic [31:0] w);
    adr = a; re = 1'b1;
    #1;
    total++; if (rdy !== 1'b1) begin bad++; $display("FAIL hit_rdy @%0h: got %0b want 1", a, rdy); end
    @(posedge aclk); #1;
    re = 1'b0;
    total++; if (dr !== w || rreq !== 1'b0) begin bad++; $display("FAIL hit_dr @%0h: got %0h rreq=%0b want %0h 0", a, dr, rreq, w); end
  endtask

  task automatic test_reset();
    arst_n = 1'b0; clr = 1'b0; base = B; adr = 32'h0; re = 1'b0; rack = 1'b0; rdata = 64'h0;
    #12;
    total++; if (rreq !== 1'b0) begin bad++; $display("FAIL reset_rreq: got %0b want 0", rreq); end
    total++; if (radr !== 32'h0) begin bad++; $display("FAIL reset_radr: got %0h want 0", radr); end
    total++; if (dr !== 32'h0) begin bad++; $display("FAIL reset_dr: got %0h want 0", dr); end
    total++; if (rlen !== 8'd15) begin bad++; $display("FAIL reset_rlen: got %0d want 15", rlen); end
    total++; if (rdy !== 1'b1) begin bad++; $display("FAIL reset_rdy_idle: got %0b want 1", rdy); end
    @(posedge aclk); #1;
    arst_n = 1'b1;
    re = 1'b1;
    #1;
    total++; if (rdy !== 1'b0) begin bad++; $display("FAIL reset_rdy_cold: got %0b want 0", rdy); end
    re = 1'b0;
    @(posedge aclk); #1;
  endtask

  task automatic test_cold_miss();
    int c;
    miss_and_fill(32'h0, B, 0, -1, c);
    total++; if (c !== 16) begin bad++; $display("FAIL cold_fill_cycles: got %0d want 16", c); end
  endtask

  task automatic test_stream();
    for (int i = 0; i <= 4; i++) begin
      if (i > 0) begin
        total++; if (dr !== 32'(i-1)) begin bad++; $display("FAIL stream_dr%0d: got %0h want %0h", i-1, dr, i-1); end
      end
      if (i < 4) begin
        adr = 32'(4*i); re = 1'b1;
        #1;
        total++; if (rdy !== 1'b1 || rreq !== 1'b0) begin bad++; $display("FAIL stream_rdy%0d: rdy=%0b rreq=%0b want 1 0", i, rdy, rreq); end
        @(posedge aclk); #1;
      end else begin
        re = 1'b0;
      end
    end
  endtask

  task automatic test_line_cross();
    int c;
    hit_read(32'h7C, 32'd31);
    miss_and_fill(32'h80, B + 32'h80, 0, -1, c);
    hit_read(32'h84, 32'd33);
    miss_and_fill(32'h200, B + 32'h200, 0, -1, c);
    miss_and_fill(32'h0, B, 0, -1, c);
    hit_read(32'hBC, 32'd47);
    // Same effective address reached through a different base.
    base = 32'h0FFF_FF00;
    hit_read(32'h10C, 32'd3);
    base = B;
  endtask

  task automatic test_clr();
    int c;
    miss_and_fill(32'h100, B + 32'h100, 0, 5, c);
    total++; if (c !== 16) begin bad++; $display("FAIL clr_all_beats: got %0d want 16", c); end
    miss_and_fill(32'h100, B + 32'h100, 0, 15, c);
    miss_and_fill(32'h104, B + 32'h100, 0, -1, c);
    // Clear coincident with a hit: served, then everything misses.
    adr = 32'h100; re = 1'b1; clr = 1'b1;
    #1;
    total++; if (rdy !== 1'b1) begin bad++; $display("FAIL clr_idle_rdy: got %0b want 1", rdy); end
    @(posedge aclk); #1;
    clr = 1'b0;
    total++; if (dr !== 32'd64) begin bad++; $display("FAIL clr_idle_dr: got %0h want 40", dr); end
    #1;
    total++; if (rdy !== 1'b0) begin bad++; $display("FAIL clr_after_rdy: got %0b want 0", rdy); end
    adr = 32'h0;
    #1;
    total++; if (rdy !== 1'b0) begin bad++; $display("FAIL clr_other_line: got %0b want 0", rdy); end
    re = 1'b0;
    @(posedge aclk); #1;
  endtask

  task automatic test_rack_gaps();
    int c;
    miss_and_fill(32'h188, B + 32'h180, 1, -1, c);
    total++; if (c !== 32) begin bad++; $display("FAIL gap_cycles: got %0d want 32", c); end
    hit_read(32'h1FC, 32'd127);
  endtask

  task automatic test_reset_mid_fill();
    int c;
    adr = 32'h300; re = 1'b1;
    @(posedge aclk); #1;
    total++; if (rreq !== 1'b1) begin bad++; $display("FAIL rmf_rreq_rise: got %0b want 1", rreq); end
    for (int k = 0; k < 8; k++) begin
      rack = 1'b1; rdata = {mem_word(B + 32'h300, 2*k+1), mem_word(B + 32'h300, 2*k)};
      @(posedge aclk); #1;
    end
    arst_n = 1'b0; rack = 1'b0; re = 1'b0;
    #1;
    total++; if (rreq !== 1'b0 || dr !== 32'h0 || rdy !== 1'b1) begin
      bad++; $display("FAIL rmf_reset: rreq=%0b dr=%0h rdy=%0b want 0 0 1", rreq, dr, rdy);
    end
    @(posedge aclk); #1;
    arst_n = 1'b1;
    @(posedge aclk); #1;
    miss_and_fill(32'h180, B + 32'h180, 0, -1, c);
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_stream();
    test_line_cross();
    test_clr();
    test_rack_gaps();
    test_reset_mid_fill();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/param_rdcache.md
# param_rdcache

Small direct-mapped read cache serving 32-bit parameter words (bias int32, quant uint32) to the accelerator core's d/e read buses. One instance per bus. Core-side requests are base plus byte offset, answered with one-cycle registered latency on hits. Misses fill a 128-byte line from DRAM through a fixed-length burst read port on the same aclk domain.

## Interface
- NLINE, 4: number of lines (power of 2); line = 128 B = 16 beats of 64 bits.
- BLEN, 16: beats per fill burst; fixed, rlen = BLEN-1.
- aclk  in  1  clock; single clock domain.
- arst_n  in  1  reset; asynchronous, active-low.
- clr  in  1  invalidate all lines (one-cycle pulse, from clreq bit).
- base  in  32  region base address (byte).
- adr  in  32  byte offset; bits [1:0] ignored (word aligned).
- re  in  1  read enable.
- rdy  out  1  request accepted / no fill pending (combinational).
- dr  out  32  read data, registered.
- rreq  out  1  burst read request, held for the whole burst.
- rack  in  1  beat valid; rdata carries one beat when high.
- radr  out  32  burst start address, 128-B aligned.
- rlen  out  8  burst length - 1 (constant BLEN-1).
- rdata  in  64  beat data, little-endian words (word0 = [31:0]).

## Operation
- Effective address ea = base + adr, modulo 2^32. Fields: index = ea[6+log2(NLINE):7], tag = ea[31:7+log2(NLINE)], beat = ea[6:3], half = ea[2].
- Storage: NLINE x 16 x 64-bit data array, per-line tag and valid bit.
- hit = valid[index] && tag[index] == tag(ea).
- rdy = (state == Idle) && !(re && !hit).
- On each edge with re && rdy: dr <= half ? data[index][beat][63:32] : data[index][beat][31:0]. Otherwise dr holds.
- FSM states: Idle, Fill.
  - Idle -> Fill on re && !hit. Latch fill index and tag, radr <= {ea[31:7], 7'h00}, rreq <= 1, beat counter <= 0, keep <= 1.
  - Fill: each cycle with rack, write rdata to data[fill index][cnt] and increment cnt.
  - Fill on the rack with cnt == 15: rreq <= 0, tag[fill index] <= fill tag, valid <= keep, return to Idle.
- In Fill, re/adr/base are ignored and rdy = 0. The request is re-evaluated in Idle the cycle after the fill ends and hits.
- clr: clears all valid bits in that cycle.
  - If clr arrives during Fill, keep <= 0. The burst still consumes all 16 beats, but the line is not validated.
  - clr coincident with the last beat: line is not validated.
  - clr in Idle with re asserted in the same cycle: hit is evaluated against the pre-clear valid bits. That access is served. Subsequent accesses miss.
- Eviction: a miss to an occupied index overwrites it; no write-back (read-only).

## Timing
- Reset values:
  - rreq=0, radr=0, dr=0, state=Idle, all valid=0, cnt=0.
  - rlen is always BLEN-1.
  - rdy=1 while re=0; with re=1 after reset, rdy=0 (cold miss).
- Hit latency: adr presented with re && rdy at edge N; dr valid after edge N.
- Back-to-back hits stream one word per cycle; consecutive addresses across a line boundary stall only if the next line misses.
- Miss penalty:
  - rreq rises 1 cycle after the miss edge.
  - The 16th rack returns to Idle.
  - rdy rises combinationally in the next cycle.
  - dr is valid one edge later.
  - Minimum 1 + 16 + 1 cycles when rack is continuous.
- rack gaps: a low rack stalls cnt; no timeout.
- radr/rlen are stable while rreq=1.
- Asynchronous reset mid-fill: immediate return to reset values. The memory side must tolerate the request being dropped.

## Test plan
- Cold miss: base=0x1000_0000, adr=0x0, re=1. Expect rreq=1 next cycle, radr=0x1000_0000, rlen=15. Feed 16 beats (beat k = {2k+1, 2k}). Then rdy=1, and dr=0 one cycle after acceptance.
- Streaming hits: after the fill, adr=0x0,0x4,0x8,0xC on consecutive cycles with re=1. Expect rdy held 1 and dr = 0,1,2,3 on successive cycles, no rreq.
- Line cross plus eviction: adr=0x7C then 0x80. Expect 0x7C dr=31 with no fill, then a miss with radr=0x1000_0080. Then adr=0x200 (same index 0) misses, evicting the 0x0 line, and re-reading 0x0 misses again.
- clr mid-fill: pulse clr at beat 5 of a fill. Expect all 16 beats consumed and rreq drop. The same address then misses again with a new burst.
- rack gaps: rack asserted every other cycle. Expect cnt advance only on rack, radr stable, and the fill completing after 32 cycles with correct data.
- Reset mid-fill: drop arst_n at beat 8. Expect rreq=0, dr=0, rdy=1 immediately. After release, a previously filled address misses.
